// File: rtl/udp_pkt_pkg.sv
// Shared types and sizing helpers for the JPEG-to-UDP packetizer.
package udp_pkt_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PREFETCH  = 3'd1,
        LAUNCH    = 3'd2,
        STREAM    = 3'd3,
        WAIT_DONE = 3'd4,
        GAP       = 3'd5
    } state_t;

    localparam int WORD_BYTES = 16;
    localparam int HDR_BYTES  = 2;

    function automatic logic [23:0] pkt_bytes(input logic [23:0] rem, input logic [23:0] max_b);
        return (rem < max_b) ? rem : max_b;
    endfunction

    // Rounds up without forming bytes+15, so it cannot overflow near 2^24.
    function automatic logic [23:0] word_count(input logic [23:0] bytes);
        return (bytes >> $clog2(WORD_BYTES)) + 24'((bytes & 24'(WORD_BYTES - 1)) != 24'd0);
    endfunction

endpackage

// File: rtl/udp_req_edge.sv
// Rising-edge detector for stretched sender strobes; the rise output is combinational,
// one cycle wide, so a multi-cycle pulse is counted exactly once.
module udp_req_edge (
    input  logic i_udp_clk50m,
    input  logic i_rst_n,
    input  logic sig,
    output logic rise
);
    logic sig_q;

    always_ff @(posedge i_udp_clk50m or negedge i_rst_n) begin
        if (!i_rst_n) sig_q <= 1'b0;
        else          sig_q <= sig;
    end

    assign rise = sig & ~sig_q;
endmodule

// File: rtl/udp_jpeg_packetizer.sv
// Splits one FIFO-resident JPEG frame into UDP packets; a word advances the cycle after each request edge.
// FIFO pops stall on i_fifo_empty (late refills flag underrun), launches wait on the sender going idle plus the IPG.
module udp_jpeg_packetizer
    import udp_pkt_pkg::*;
#(
    parameter int          MAX_PAYLOAD    = 1024,
    parameter logic [15:0] IPG_CYCLES     = 16'd500,
    parameter logic [15:0] IPV4_SIGN_INIT = 16'h0000
) (
    input  logic         i_udp_clk50m,
    input  logic         i_rst_n,
    input  logic         i_frame_start,
    input  logic [23:0]  i_frame_len,
    output logic         o_fifo_rd_en,
    input  logic [127:0] i_fifo_rd_data,
    input  logic         i_fifo_empty,
    output logic         o_send_en,
    output logic [127:0] o_wrdata,
    output logic         o_last_frame_flag,
    output logic [14:0]  o_frame_rank,
    output logic [15:0]  o_jpeg_len,
    output logic [15:0]  o_ipv4_sign,
    input  logic         i_data_upd_req,
    input  logic         i_frame_down,
    input  logic         i_send_busy,
    output logic         o_busy,
    output logic         o_frame_done,
    output logic         o_err,
    output logic [2:0]   o_state
);
    localparam logic [23:0] MAX_B = 24'(MAX_PAYLOAD);

    state_t       state;
    logic [23:0]  remaining, pkt_len, frame_words_left;
    logic [15:0]  pkt_words, words_sent, need, gap_cnt;
    logic [127:0] next_word;
    logic         cur_vld, nxt_vld, adv_pend, rd_q, busy_q;
    logic         req_rise, done_rise;
    logic         adv, refill, issue, arrive, pf_ready;
    logic [23:0]  start_pkt, next_pkt;
    logic [15:0]  start_pw, next_pw;

    udp_req_edge u_req_edge  (.i_udp_clk50m, .i_rst_n, .sig(i_data_upd_req), .rise(req_rise));
    udp_req_edge u_done_edge (.i_udp_clk50m, .i_rst_n, .sig(i_frame_down),   .rise(done_rise));

    assign start_pkt = pkt_bytes(i_frame_len, MAX_B);
    assign next_pkt  = pkt_bytes(remaining, MAX_B);
    assign start_pw  = 16'(word_count(start_pkt));
    assign next_pw   = 16'(word_count(next_pkt));

    // Refills are only requested while the packet still has undelivered words beyond next_word,
    // so each packet pops exactly its own word count.
    assign adv      = (state == STREAM) && req_rise && (words_sent < pkt_words - 16'd1);
    assign refill   = adv && (words_sent + 16'd2 < pkt_words);
    // Pops are spaced a cycle apart so the registered pop never acts on a stale empty flag.
    assign issue    = ((state == PREFETCH) || (state == STREAM)) && (need != 16'd0) &&
                      !i_fifo_empty && !o_fifo_rd_en && (frame_words_left != 24'd0);
    assign arrive   = rd_q && (state != IDLE);
    assign pf_ready = cur_vld && (nxt_vld || pkt_words < 16'd2) && (need == 16'd0) && !o_fifo_rd_en && !rd_q;
    assign o_state  = state;

    always_ff @(posedge i_udp_clk50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            remaining <= '0; pkt_len <= '0; frame_words_left <= '0;
            pkt_words <= '0; words_sent <= '0; need <= '0; gap_cnt <= '0;
            next_word <= '0; cur_vld <= 1'b0; nxt_vld <= 1'b0; adv_pend <= 1'b0;
            rd_q <= 1'b0; busy_q <= 1'b0;
            o_fifo_rd_en <= 1'b0; o_send_en <= 1'b0; o_wrdata <= '0;
            o_last_frame_flag <= 1'b0; o_frame_rank <= '0; o_jpeg_len <= '0;
            o_ipv4_sign <= IPV4_SIGN_INIT; o_busy <= 1'b0; o_frame_done <= 1'b0; o_err <= 1'b0;
        end else begin
            o_send_en    <= 1'b0;
            o_frame_done <= 1'b0;
            o_fifo_rd_en <= issue;
            rd_q         <= o_fifo_rd_en;
            busy_q       <= i_send_busy;
            need         <= need + 16'(refill) - 16'(issue);
            if (issue) frame_words_left <= frame_words_left - 24'd1;

            if (adv) begin
                words_sent <= words_sent + 16'd1;
                if (nxt_vld) begin
                    o_wrdata <= next_word;
                    if (arrive) next_word <= i_fifo_rd_data;
                    else        nxt_vld   <= 1'b0;
                end else if (arrive) begin
                    o_wrdata <= i_fifo_rd_data;
                end else begin
                    o_err    <= 1'b1;
                    adv_pend <= 1'b1;
                end
            end else if (arrive) begin
                if (adv_pend || !cur_vld) begin
                    o_wrdata <= i_fifo_rd_data;
                    cur_vld  <= 1'b1;
                    adv_pend <= 1'b0;
                end else begin
                    next_word <= i_fifo_rd_data;
                    nxt_vld   <= 1'b1;
                end
            end

            case (state)
                IDLE: if (i_frame_start && i_frame_len != 24'd0) begin
                    remaining        <= i_frame_len;
                    frame_words_left <= word_count(i_frame_len);
                    pkt_len          <= start_pkt;
                    pkt_words        <= start_pw;
                    need             <= (start_pw >= 16'd2) ? 16'd2 : 16'd1;
                    o_frame_rank     <= '0;
                    o_err            <= 1'b0;
                    o_busy           <= 1'b1;
                    cur_vld <= 1'b0; nxt_vld <= 1'b0; adv_pend <= 1'b0;
                    state            <= PREFETCH;
                end
                PREFETCH: if (pf_ready) begin
                    o_jpeg_len        <= pkt_len[15:0];
                    o_last_frame_flag <= (remaining <= MAX_B);
                    words_sent        <= '0;
                    o_send_en         <= 1'b1;
                    state             <= LAUNCH;
                end
                LAUNCH: state <= STREAM;
                STREAM: begin
                    if (done_rise) begin
                        state <= WAIT_DONE;
                    end else if (busy_q && !i_send_busy) begin
                        o_err        <= 1'b1;
                        o_busy       <= 1'b0;
                        o_fifo_rd_en <= 1'b0;
                        need         <= '0;
                        cur_vld <= 1'b0; nxt_vld <= 1'b0; adv_pend <= 1'b0;
                        state        <= IDLE;
                    end
                end
                WAIT_DONE: if (!i_send_busy) begin
                    remaining    <= remaining - pkt_len;
                    o_frame_rank <= o_frame_rank + 15'd1;
                    o_ipv4_sign  <= o_ipv4_sign + 16'd1;
                    cur_vld <= 1'b0; nxt_vld <= 1'b0; adv_pend <= 1'b0;
                    if (remaining == pkt_len) begin
                        o_frame_done <= 1'b1;
                        o_busy       <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        gap_cnt <= '0;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt + 16'd1 >= IPG_CYCLES) begin
                        pkt_len   <= next_pkt;
                        pkt_words <= next_pw;
                        need      <= (next_pw >= 16'd2) ? 16'd2 : 16'd1;
                        state     <= PREFETCH;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/udp_jpeg_packetizer.md
Name: udp_jpeg_packetizer

Overview:
Upstream feeder for the 128-bit UDP byte sender. It takes one JPEG frame (already in the DDR3 read FIFO, zero-padded to a 16-byte boundary) and splits it into UDP packets of at most MAX_PAYLOAD bytes. For each packet it drives the sender's start, length, rank, last-flag and IPv4-ID inputs, and supplies 128-bit words on each sender word request. It owns inter-packet gap timing and frame completion signalling.

Parameters:
MAX_PAYLOAD, 1024, maximum JPEG bytes per packet; multiple of 16, ≤ 1456
IPG_CYCLES, 16'd500, idle clocks between the sender going non-busy and the next packet launch
IPV4_SIGN_INIT, 16'h0000, IPv4 identification value after reset

Ports:
i_udp_clk50m  in  1  clock, 50 MHz
i_rst_n  in  1  asynchronous active-low reset
i_frame_start  in  1  one-cycle pulse; starts a frame (ignored unless IDLE)
i_frame_len  in  24  frame length in bytes; sampled with i_frame_start
o_fifo_rd_en  out  1  DDR3 read-FIFO pop; data is valid 1 cycle later
i_fifo_rd_data  in  128  FIFO word; byte 0 is in [127:120]
i_fifo_empty  in  1  FIFO empty
o_send_en  out  1  sender start pulse
o_wrdata  out  128  current word presented to the sender
o_last_frame_flag  out  1  current packet is the final packet of the frame
o_frame_rank  out  15  packet index within the frame
o_jpeg_len  out  16  payload bytes in the current packet
o_ipv4_sign  out  16  IPv4 identification for the current packet
i_data_upd_req  in  1  sender word request; stretched to 3 cycles
i_frame_down  in  1  sender packet done; stretched to 4 cycles
i_send_busy  in  1  sender busy
o_busy  out  1  frame in progress
o_frame_done  out  1  one-cycle pulse after the last packet completes
o_err  out  1  sticky; underrun or abort; cleared by i_frame_start
o_state  out  3  current FSM state

Behaviour:
- Clock i_udp_clk50m; reset i_rst_n, asynchronous, active-low.
- Reset values:
  - all outputs 0, except o_ipv4_sign = IPV4_SIGN_INIT
  - state IDLE; internal counters 0
- Edge detection: i_data_upd_req and i_frame_down are edge-detected against a 1-cycle registered copy. A stretched pulse counts exactly once.
- Packet sizing:
  - remaining = frame_len
  - pkt_len = min(remaining, MAX_PAYLOAD)
  - words = ceil(pkt_len/16)
  - 24-bit arithmetic; pkt_len is truncated to 16 bits for o_jpeg_len.
- FSM states:
  - IDLE: on i_frame_start with i_frame_len≠0, latch length, rank←0, clear o_err, o_busy←1 → PREFETCH. A zero length is ignored and stays IDLE.
  - PREFETCH: pop 2 words into o_wrdata and the next_word register, waiting while i_fifo_empty. Load o_jpeg_len and o_last_frame_flag = (remaining ≤ MAX_PAYLOAD) → LAUNCH.
  - LAUNCH: o_send_en=1 for exactly 1 cycle → STREAM. Packet metadata (o_jpeg_len, o_last_frame_flag, o_frame_rank, o_ipv4_sign) is held stable until WAIT_DONE exits.
  - STREAM, on each request rising edge while words_sent < words-1:
    - o_wrdata←next_word; words_sent++
    - pop a refill if words_sent+1 < words, and the frame has words left
    - a refill pop waits while i_fifo_empty
    - if next_word is not yet valid at the edge, set o_err (underrun); the word is still delivered when it arrives
  - STREAM, request edges beyond words-1 are ignored.
  - STREAM exits: rising edge of i_frame_down → WAIT_DONE. i_send_busy falling before i_frame_down → abort: o_err←1, drain nothing → IDLE, o_busy←0.
  - WAIT_DONE: wait for i_send_busy=0. Then remaining -= pkt_len, rank++, o_ipv4_sign++ (wraps FFFF→0000).
    - remaining=0 → IDLE, o_frame_done pulse, o_busy←0
    - otherwise → GAP
  - GAP: count IPG_CYCLES → PREFETCH.
- Prefetch state across packets: next_word already holding the following packet's first word is permitted. PREFETCH then pops only what is missing.
- Full-frame byte count is consumed exactly: total pops = ceil(frame_len/16).
- i_frame_start outside IDLE is ignored.
- Reset mid-operation returns to the reset values immediately; the FIFO is not flushed by this block.

Decomposition:
- Package udp_pkt_pkg:
  - state enum {IDLE, PREFETCH, LAUNCH, STREAM, WAIT_DONE, GAP}
  - WORD_BYTES=16, HDR_BYTES=2
- One sub-module: udp_req_edge, the rise detector used for both i_data_upd_req and i_frame_down.

Test Plan:
- len=1024, FIFO preloaded with 64 words → one o_send_en; o_jpeg_len=1024, rank 0, last=1; 64 pops; o_frame_done once; o_err=0.
- len=2500 → three packets:
  - o_jpeg_len 1024/1024/452
  - ranks 0/1/2, last only on rank 2
  - o_ipv4_sign N, N+1, N+2
  - ≥500 idle cycles between busy-fall and next o_send_en
  - 157 pops total
- 3-cycle stretched i_data_upd_req → o_wrdata advances exactly once per pulse; a sequence of 20 pulses on a 17-word packet → 16 advances, extras ignored.
- i_fifo_empty held for 30 cycles during PREFETCH → o_send_en delayed; no pop while empty; data order intact.
- i_send_busy drops mid-STREAM without i_frame_down → o_err=1, state IDLE, o_busy=0, no o_frame_done.
- len=0 start pulse, and a start pulse while busy → no state change, no pops; reset asserted mid-STREAM → all outputs at reset values the same cycle.
